// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-side hazard and forwarding controller for the pipelined MIPS datapath.
//
// Tracks every in-flight register write in a DEPTH-entry age queue (entry 0 = EX, DEPTH-1 = WB)
// and derives the decode stall, per-operand forward selects and branch/jump flush. A saturating
// counter records stall cycles for performance measurement.
//
// Build option:
//   HAZARD_FWD_EN  defined   -> load-aware forwarding; fwd_*_o select the youngest producer.
//   HAZARD_FWD_EN  undefined -> no forwarding; any matched producer short of WB stalls and
//                               fwd_*_o are tied to 0.
//
// Parameters:
//   REG_W     register address width
//   DEPTH     tracked stages after ID (minimum 2)
//   ALU_LAT   entry index at which a non-load result becomes forwardable
//   LOAD_LAT  entry index at which load data becomes forwardable (ALU_LAT <= LOAD_LAT < DEPTH)
//   CNT_W     stall counter width
//   FS_W      forward-select width
//
// Ports:
//   clk_i                        clock, all state on the rising edge
//   rst_i                        synchronous active-high reset
//   advance_i                    pipeline advances this cycle (0 freezes the queue)
//   id_valid_i                   ID holds a real instruction
//   id_rs_i, id_rt_i             source registers
//   id_uses_rs_i, id_uses_rt_i   operand is actually read
//   id_wen_i, id_wreg_i          instruction writes register id_wreg_i
//   id_is_load_i                 instruction is LW
//   id_is_beq_i, id_is_bne_i     conditional branch resolved in ID
//   id_is_jump_i                 J, JAL or JR
//   id_equal_i                   ID comparator result
//   stall_o                      hold PC and IF/ID, insert bubble into EX
//   flush_o                      squash IF/ID
//   branch_taken_o               redirect PC to the branch target
//   fwd_rs_o, fwd_rt_o           0 = register file, k+1 = queue entry k
//   stall_cnt_o                  saturating stall-cycle count
module hazard_scoreboard #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned ALU_LAT  = 0,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned FS_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             advance_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rs_i,
    input  logic             id_uses_rt_i,
    input  logic             id_wen_i,
    input  logic [REG_W-1:0] id_wreg_i,
    input  logic             id_is_load_i,
    input  logic             id_is_beq_i,
    input  logic             id_is_bne_i,
    input  logic             id_is_jump_i,
    input  logic             id_equal_i,
    output logic             stall_o,
    output logic             flush_o,
    output logic             branch_taken_o,
    output logic [FS_W-1:0]  fwd_rs_o,
    output logic [FS_W-1:0]  fwd_rt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // Age queue of in-flight writes
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] load_q, load_d;
    logic [REG_W-1:0] wreg_q [DEPTH];
    logic [REG_W-1:0] wreg_d [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Per-operand match results
    logic            rs_hit, rt_hit;
    logic [FS_W-1:0] rs_idx, rt_idx;
    logic            rs_load, rt_load;
    logic            rs_haz, rt_haz;

    // Youngest-match search. Scanning from the oldest entry down to entry 0 lets the youngest
    // match overwrite any older one.
    always_comb begin
        rs_hit  = 1'b0;
        rs_idx  = '0;
        rs_load = 1'b0;
        rt_hit  = 1'b0;
        rt_idx  = '0;
        rt_load = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (valid_q[k] && (wreg_q[k] == id_rs_i)) begin
                rs_hit  = 1'b1;
                rs_idx  = FS_W'(k);
                rs_load = load_q[k];
            end
            if (valid_q[k] && (wreg_q[k] == id_rt_i)) begin
                rt_hit  = 1'b1;
                rt_idx  = FS_W'(k);
                rt_load = load_q[k];
            end
        end
        // $0 is hardwired; unused operands never create a dependency
        rs_hit = rs_hit & id_uses_rs_i & (id_rs_i != '0);
        rt_hit = rt_hit & id_uses_rt_i & (id_rt_i != '0);
    end

`ifdef HAZARD_FWD_EN
    logic        is_branch;
    int unsigned rs_need, rt_need;

    assign is_branch = id_is_beq_i | id_is_bne_i;

    always_comb begin
        // Branches compare in ID, so they need the value one stage before EX would
        rs_need = (rs_load ? LOAD_LAT : ALU_LAT) + (is_branch ? 32'd1 : 32'd0);
        rt_need = (rt_load ? LOAD_LAT : ALU_LAT) + (is_branch ? 32'd1 : 32'd0);
        rs_haz  = rs_hit && (32'(rs_idx) < rs_need);
        rt_haz  = rt_hit && (32'(rt_idx) < rt_need);
        fwd_rs_o = (id_valid_i && rs_hit) ? rs_idx + FS_W'(1) : '0;
        fwd_rt_o = (id_valid_i && rt_hit) ? rt_idx + FS_W'(1) : '0;
    end
`else
    // Without bypass paths only WB is safe: it writes the register file before ID reads it
    always_comb begin
        rs_haz   = rs_hit && (32'(rs_idx) < DEPTH - 1);
        rt_haz   = rt_hit && (32'(rt_idx) < DEPTH - 1);
        fwd_rs_o = '0;
        fwd_rt_o = '0;
    end

    logic unused_cfg;
    assign unused_cfg = ^{rs_load, rt_load, ALU_LAT, LOAD_LAT};
`endif

    assign stall_o        = id_valid_i & (rs_haz | rt_haz);
    assign branch_taken_o = id_valid_i & ~stall_o &
                            ((id_is_beq_i & id_equal_i) | (id_is_bne_i & ~id_equal_i));
    assign flush_o        = branch_taken_o | (id_valid_i & ~stall_o & id_is_jump_i);
    assign stall_cnt_o    = cnt_q;

    always_comb begin
        valid_d = valid_q;
        load_d  = load_q;
        wreg_d  = wreg_q;
        cnt_d   = cnt_q;
        if (advance_i) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                valid_d[k] = valid_q[k-1];
                load_d[k]  = load_q[k-1];
                wreg_d[k]  = wreg_q[k-1];
            end
            // A stalled instruction stays in ID, so EX receives a bubble
            valid_d[0] = id_valid_i & id_wen_i & (id_wreg_i != '0) & ~stall_o;
            load_d[0]  = id_is_load_i;
            wreg_d[0]  = id_wreg_i;
            if (stall_o && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            load_q  <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                wreg_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            load_q  <= load_d;
            wreg_q  <= wreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard. Each cycle's expected outputs are pushed to a
// scoreboard queue when the ID inputs are driven and popped/compared at the falling edge.
// Expectations cover both builds (HAZARD_FWD_EN defined or not). A 4-bit counter is used so
// saturation is reachable quickly.
module tb_hazard_scoreboard;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned DEPTH   = 3;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned FS_W    = $clog2(DEPTH + 1);
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             advance;
    logic             id_valid;
    logic [REG_W-1:0] id_rs, id_rt, id_wreg;
    logic             id_uses_rs, id_uses_rt, id_wen, id_is_load;
    logic             id_is_beq, id_is_bne, id_is_jump, id_equal;
    logic             stall, flush, branch_taken;
    logic [FS_W-1:0]  fwd_rs, fwd_rt;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_W   (REG_W),
        .DEPTH   (DEPTH),
        .ALU_LAT (0),
        .LOAD_LAT(1),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .advance_i     (advance),
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rs_i  (id_uses_rs),
        .id_uses_rt_i  (id_uses_rt),
        .id_wen_i      (id_wen),
        .id_wreg_i     (id_wreg),
        .id_is_load_i  (id_is_load),
        .id_is_beq_i   (id_is_beq),
        .id_is_bne_i   (id_is_bne),
        .id_is_jump_i  (id_is_jump),
        .id_equal_i    (id_equal),
        .stall_o       (stall),
        .flush_o       (flush),
        .branch_taken_o(branch_taken),
        .fwd_rs_o      (fwd_rs),
        .fwd_rt_o      (fwd_rt),
        .stall_cnt_o   (stall_cnt)
    );

    // -1 in a forward field means "not checked" (select is meaningless while stalled)
    typedef struct {
        int stall;
        int flush;
        int bt;
        int frs;
        int frt;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   total   = 0;
    int   bad     = 0;
    int   exp_cnt = 0;

    task automatic check_val(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Queue this cycle's expectation and advance the bench's own stall-counter model
    task automatic push(input int st, input int fl, input int bt, input int frs, input int frt);
        exp_t e;
        e.stall = st;
        e.flush = fl;
        e.bt    = bt;
        e.frs   = frs;
        e.frt   = frt;
        e.cnt   = exp_cnt;
        sb.push_back(e);
        if (rst) exp_cnt = 0;
        else if (st == 1 && advance && exp_cnt < CNT_MAX) exp_cnt++;
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check_val("stall", int'(stall), e.stall);
            check_val("flush", int'(flush), e.flush);
            check_val("branch_taken", int'(branch_taken), e.bt);
            if (e.frs >= 0) check_val("fwd_rs", int'(fwd_rs), e.frs);
            if (e.frt >= 0) check_val("fwd_rt", int'(fwd_rt), e.frt);
            check_val("stall_cnt", int'(stall_cnt), e.cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        id_valid   = 1'b0;
        id_rs      = '0;
        id_rt      = '0;
        id_uses_rs = 1'b0;
        id_uses_rt = 1'b0;
        id_wen     = 1'b0;
        id_wreg    = '0;
        id_is_load = 1'b0;
        id_is_beq  = 1'b0;
        id_is_bne  = 1'b0;
        id_is_jump = 1'b0;
        id_equal   = 1'b0;
    endtask

    task automatic instr(input logic [REG_W-1:0] rs, input bit urs, input logic [REG_W-1:0] rt,
                         input bit urt, input bit wen, input logic [REG_W-1:0] wreg,
                         input bit ld);
        nop();
        id_valid   = 1'b1;
        id_rs      = rs;
        id_uses_rs = urs;
        id_rt      = rt;
        id_uses_rt = urt;
        id_wen     = wen;
        id_wreg    = wreg;
        id_is_load = ld;
    endtask

    // Hold the current ID instruction through its expected stall cycles, then let it issue
    task automatic issue(input int stalls, input int frs, input int frt, input int bt,
                         input int fl);
        for (int i = 0; i < stalls; i++) begin
            push(1, 0, 0, -1, -1);
            tick();
        end
        push(0, fl, bt, frs, frt);
        tick();
    endtask

    task automatic drain();
        nop();
        for (int i = 0; i < DEPTH; i++) begin
            push(0, 0, 0, 0, 0);
            tick();
        end
    endtask

    initial begin
        nop();
        advance = 1'b1;
        rst     = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset
        drain();

        // ALU producer, back-to-back consumer, then a consumer one cycle later
        instr(5'd1, 1, 5'd2, 1, 1, 5'd3, 0);
        issue(0, 0, 0, 0, 0);
        instr(5'd3, 1, 5'd0, 0, 1, 5'd8, 0);
        issue(FWD ? 0 : 2, FWD ? 1 : 0, 0, 0, 0);
        instr(5'd3, 1, 5'd0, 1, 0, 5'd0, 0);
        issue(0, FWD ? 2 : 0, 0, 0, 0);
        drain();

        // Load-use on rt
        instr(5'd1, 1, 5'd0, 0, 1, 5'd4, 1);
        issue(0, 0, 0, 0, 0);
        instr(5'd1, 1, 5'd4, 1, 1, 5'd10, 0);
        issue(FWD ? 1 : 2, 0, FWD ? 2 : 0, 0, 0);
        drain();

        // Load then dependent BEQ (taken): flush suppressed while stalled
        instr(5'd1, 1, 5'd0, 0, 1, 5'd5, 1);
        issue(0, 0, 0, 0, 0);
        instr(5'd5, 1, 5'd1, 1, 0, 5'd0, 0);
        id_is_beq = 1'b1;
        id_equal  = 1'b1;
        issue(2, FWD ? 3 : 0, 0, 1, 1);
        drain();

        // ALU then dependent BNE (taken)
        instr(5'd1, 1, 5'd2, 1, 1, 5'd9, 0);
        issue(0, 0, 0, 0, 0);
        instr(5'd2, 1, 5'd9, 1, 0, 5'd0, 0);
        id_is_bne = 1'b1;
        id_equal  = 1'b0;
        issue(FWD ? 1 : 2, 0, FWD ? 2 : 0, 1, 1);
        drain();

        // Jump flushes without redirect; BEQ not taken does nothing
        instr(5'd0, 0, 5'd0, 0, 0, 5'd0, 0);
        id_is_jump = 1'b1;
        issue(0, 0, 0, 0, 1);
        instr(5'd1, 1, 5'd2, 1, 0, 5'd0, 0);
        id_is_beq = 1'b1;
        id_equal  = 1'b0;
        issue(0, 0, 0, 0, 0);
        drain();

        // Two writers of $6: the youngest wins
        instr(5'd1, 1, 5'd2, 1, 1, 5'd6, 0);
        issue(0, 0, 0, 0, 0);
        instr(5'd1, 1, 5'd2, 1, 1, 5'd6, 0);
        issue(0, 0, 0, 0, 0);
        instr(5'd6, 1, 5'd0, 1, 0, 5'd0, 0);
        issue(FWD ? 0 : 2, FWD ? 1 : 0, 0, 0, 0);
        drain();

        // Writes to and reads of $0 never create a hazard
        instr(5'd1, 1, 5'd0, 0, 1, 5'd0, 1);
        issue(0, 0, 0, 0, 0);
        instr(5'd0, 1, 5'd0, 1, 1, 5'd16, 0);
        issue(0, 0, 0, 0, 0);
        drain();

        // Simultaneous rs (load, entry 1) and rt (ALU, entry 0) dependencies
        instr(5'd1, 1, 5'd0, 0, 1, 5'd11, 1);
        issue(0, 0, 0, 0, 0);
        instr(5'd1, 1, 5'd2, 1, 1, 5'd12, 0);
        issue(0, 0, 0, 0, 0);
        instr(5'd11, 1, 5'd12, 1, 0, 5'd0, 0);
        issue(FWD ? 0 : 2, FWD ? 2 : 0, FWD ? 1 : 0, 0, 0);
        drain();

        // Repeated load-use pairs drive the counter into saturation
        for (int p = 0; p < 16; p++) begin
            instr(5'd1, 1, 5'd0, 0, 1, 5'd13, 1);
            issue(0, 0, 0, 0, 0);
            instr(5'd13, 1, 5'd2, 1, 1, 5'd14, 0);
            issue(FWD ? 1 : 2, FWD ? 2 : 0, 0, 0, 0);
        end
        drain();

        // Frozen pipe holds the hazard and the counter; reset mid-hold clears both
        instr(5'd1, 1, 5'd0, 0, 1, 5'd7, 1);
        issue(0, 0, 0, 0, 0);
        instr(5'd7, 1, 5'd2, 1, 1, 5'd15, 0);
        advance = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(1, 0, 0, FWD ? 1 : 0, 0);
            tick();
        end
        rst = 1'b1;
        push(1, 0, 0, FWD ? 1 : 0, 0);
        tick();
        rst = 1'b0;
        push(0, 0, 0, 0, 0);
        tick();
        advance = 1'b1;
        push(0, 0, 0, 0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
